// File: rtl/mem_port_arbiter_pkg.sv
// memarb_pkg: shared definitions for the memory-port arbiter.
//   - state_t      : arbiter FSM states (IDLE, BUSY, RELEASE)
//   - clog2()      : index width helper, never returns less than 1
//   - DEF_*        : default widths used by the top and its interface
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_SUB_W   = 128;
  localparam int DEF_STRB_W  = 2;
  localparam int DEF_TIMEOUT = 1024;

  // Width of an index into n items; a single item still gets one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: the single off-chip memory-controller port.
//   master : the arbiter side (drives mem_en/we/addr/wstrobe/wdata,
//            receives mem_rstrobe/rdata/accR/accW/ready)
//   slave  : the memory-controller side (the reverse directions)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int SUB_W  = 128,
  parameter int STRB_W = 2
);

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrobe;
  logic [SUB_W-1:0]  mem_wdata;
  logic [STRB_W-1:0] mem_rstrobe;
  logic [SUB_W-1:0]  mem_rdata;
  logic              mem_accR;
  logic              mem_accW;
  logic              mem_ready;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wstrobe, mem_wdata,
    input  mem_rstrobe, mem_rdata, mem_accR, mem_accW, mem_ready
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wstrobe, mem_wdata,
    output mem_rstrobe, mem_rdata, mem_accR, mem_accW, mem_ready
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req       in  NREQ   request vector
//   ptr       in  IDX_W  index of the last winner
//   grant_idx out IDX_W  first asserted index after ptr (wrapping)
//   grant_oh  out NREQ   one-hot form of grant_idx (0 when !valid)
//   valid     out 1      any request asserted
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic [NREQ-1:0]  grant_oh,
  output logic             valid
);

  int j;

  // Scan from the farthest offset down to ptr+1 so the nearest
  // requester after the pointer is the last (and winning) assignment.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    j         = 0;
    for (int off = NREQ; off >= 1; off--) begin
      j = int'(ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        grant_idx = j[IDX_W-1:0];
        valid     = 1'b1;
      end
    end
    grant_oh = valid ? (NREQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port among NREQ
// cache subsystems; the grant is held for a whole multi-subblock
// transaction until mem_ready. Also fans out flush and ANDs flush-done.
//   clk, reset (async, active-low)
//   req_*      : per-requester packed request side (see port list)
//   mem        : memory-controller port (mem_port_arbiter_if.master)
//   flush/req_flush/req_flushed/flushed : flush fan-out / combine
//   err, err_id: sticky watchdog error and requester that held the grant
// Optional feature: define MEMARB_WATCHDOG_EN to compile in a BUSY-state
// watchdog that aborts a transaction after TIMEOUT cycles. Without it,
// err/err_id are tied 0 and BUSY waits indefinitely.
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SUB_W   = DEF_SUB_W,
  parameter int STRB_W  = DEF_STRB_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_en,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*STRB_W-1:0]   req_wstrobe,
  input  logic [NREQ*SUB_W-1:0]    req_wdata,
  output logic [STRB_W-1:0]        req_rstrobe,
  output logic [SUB_W-1:0]         req_rdata,
  output logic [NREQ-1:0]          req_accR,
  output logic [NREQ-1:0]          req_accW,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_flushed,
  input  logic                     flush,
  output logic [NREQ-1:0]          req_flush,
  output logic                     flushed,
  mem_port_arbiter_if.master       mem,
  output logic                     err,
  output logic [clog2(NREQ)-1:0]   err_id
);

  localparam int IDX_W = clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("mem_port_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
  end

  state_t           state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [NREQ-1:0]  grant_oh, grant_oh_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic             mem_en_q, mem_en_nxt;

  logic [IDX_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_oh;
  logic             pick_valid;
  logic             busy;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req_en),
    .ptr       (rr_ptr),
    .grant_idx (pick_idx),
    .grant_oh  (pick_oh),
    .valid     (pick_valid)
  );

`ifdef MEMARB_WATCHDOG_EN
  logic [15:0]      wd_cnt;
  logic             err_q, err_nxt;
  logic [IDX_W-1:0] err_id_q, err_id_nxt;
  logic             wd_expire;

  // Counter sits at 0 while IDLE so it reads 0 on the first BUSY cycle;
  // expiry is evaluated on the TIMEOUT-th BUSY cycle.
  assign wd_expire = (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt   <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      err_q    <= err_nxt;
      err_id_q <= err_id_nxt;
      if (state == BUSY) wd_cnt <= wd_cnt + 16'd1;
      else               wd_cnt <= '0;
    end
  end

  assign err    = err_q;
  assign err_id = err_id_q;
`else
  assign err    = 1'b0;
  assign err_id = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_oh <= '0;
      rr_ptr   <= IDX_W'(NREQ - 1);
      mem_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_oh <= grant_oh_nxt;
      rr_ptr   <= rr_ptr_nxt;
      mem_en_q <= mem_en_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_oh_nxt = grant_oh;
    rr_ptr_nxt   = rr_ptr;
    mem_en_nxt   = mem_en_q;
`ifdef MEMARB_WATCHDOG_EN
    err_nxt      = err_q;
    err_id_nxt   = err_id_q;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt    = BUSY;
          grant_nxt    = pick_idx;
          grant_oh_nxt = pick_oh;
          rr_ptr_nxt   = pick_idx;
          mem_en_nxt   = 1'b1;
        end
      end
      // A granted requester dropping req_en early is ignored: only the
      // memory side can end the transaction.
      BUSY: begin
        if (mem.mem_ready) begin
          state_nxt  = RELEASE;
          mem_en_nxt = 1'b0;
        end
`ifdef MEMARB_WATCHDOG_EN
        else if (wd_expire) begin
          state_nxt  = RELEASE;
          mem_en_nxt = 1'b0;
          err_nxt    = 1'b1;
          err_id_nxt = grant;
        end
`endif
      end
      // One dead cycle so the finished requester can lower req_en
      // before the next pick.
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BUSY);

  assign mem.mem_en      = mem_en_q;
  assign mem.mem_we      = req_we[grant];
  assign mem.mem_addr    = req_addr[int'(grant)*ADDR_W +: ADDR_W];
  assign mem.mem_wstrobe = req_wstrobe[int'(grant)*STRB_W +: STRB_W];
  assign mem.mem_wdata   = req_wdata[int'(grant)*SUB_W +: SUB_W];

  assign req_rstrobe = mem.mem_rstrobe;
  assign req_rdata   = mem.mem_rdata;
  assign req_accR    = (busy && mem.mem_accR)  ? grant_oh : '0;
  assign req_accW    = (busy && mem.mem_accW)  ? grant_oh : '0;
  assign req_ready   = (busy && mem.mem_ready) ? grant_oh : '0;

  assign req_flush = {NREQ{flush}};
  assign flushed   = &req_flushed;

endmodule
